// File: rtl/circuito_exp_4.sv
// Sequence-checking game: Moore control unit plus datapath (play counter,
// 16x4 sequence ROM, switch register, comparator) with 7-segment debug outputs.
module circuito_exp_4 (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] chaves,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       maior,
  output logic       menor,
  output logic       db_igual,
  output logic       db_iniciar,
  output logic       db_zeraC,
  output logic       db_zeraR,
  output logic       db_registraR,
  output logic       db_contaC,
  output logic       db_fimC,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_chaves,
  output logic [6:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_ERROU   = 4'hE
  } estado_t;

  estado_t    estado_q, estado_d;
  logic       zera_c_q, zera_c_d;
  logic       zera_r_q, zera_r_d;
  logic       registra_r_q, registra_r_d;
  logic       conta_c_q, conta_c_d;
  logic       pronto_q, pronto_d;
  logic       acertou_q, acertou_d;
  logic       errou_q, errou_d;
  logic [3:0] contagem_q;
  logic [3:0] chaves_q;
  logic [3:0] memoria_s;
  logic       igual_s;
  logic       fim_c_s;
  logic [3:0] estado_cod_s;

  function automatic logic [3:0] rom_word(input logic [3:0] addr);
    case (addr)
      4'd0:    rom_word = 4'h1;
      4'd1:    rom_word = 4'h2;
      4'd2:    rom_word = 4'h4;
      4'd3:    rom_word = 4'h8;
      4'd4:    rom_word = 4'h4;
      4'd5:    rom_word = 4'h2;
      4'd6:    rom_word = 4'h1;
      4'd7:    rom_word = 4'h1;
      4'd8:    rom_word = 4'h2;
      4'd9:    rom_word = 4'h2;
      4'd10:   rom_word = 4'h4;
      4'd11:   rom_word = 4'h4;
      4'd12:   rom_word = 4'h8;
      4'd13:   rom_word = 4'h8;
      4'd14:   rom_word = 4'h1;
      4'd15:   rom_word = 4'h4;
      default: rom_word = 4'h0;
    endcase
  endfunction

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0:    hex7seg = 7'b1000000;
      4'h1:    hex7seg = 7'b1111001;
      4'h2:    hex7seg = 7'b0100100;
      4'h3:    hex7seg = 7'b0110000;
      4'h4:    hex7seg = 7'b0011001;
      4'h5:    hex7seg = 7'b0010010;
      4'h6:    hex7seg = 7'b0000010;
      4'h7:    hex7seg = 7'b1111000;
      4'h8:    hex7seg = 7'b0000000;
      4'h9:    hex7seg = 7'b0010000;
      4'hA:    hex7seg = 7'b0001000;
      4'hB:    hex7seg = 7'b0000011;
      4'hC:    hex7seg = 7'b1000110;
      4'hD:    hex7seg = 7'b0100001;
      4'hE:    hex7seg = 7'b0000110;
      4'hF:    hex7seg = 7'b0001110;
      default: hex7seg = 7'b1111111;
    endcase
  endfunction

  // Next-state logic; strobes are derived from the next state so they register in step with it.
  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:     estado_d = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:  estado_d = REGISTRA;
      REGISTRA:    estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual_s)     estado_d = FIM_ERROU;
        else if (fim_c_s) estado_d = FIM_ACERTOU;
        else              estado_d = PROXIMO;
      end
      PROXIMO:     estado_d = REGISTRA;
      FIM_ACERTOU: estado_d = iniciar ? PREPARACAO : FIM_ACERTOU;
      FIM_ERROU:   estado_d = iniciar ? PREPARACAO : FIM_ERROU;
      default:     estado_d = INICIAL;
    endcase
    zera_c_d     = (estado_d == PREPARACAO);
    zera_r_d     = (estado_d == PREPARACAO);
    registra_r_d = (estado_d == REGISTRA);
    conta_c_d    = (estado_d == PROXIMO);
    pronto_d     = (estado_d == FIM_ACERTOU) || (estado_d == FIM_ERROU);
    acertou_d    = (estado_d == FIM_ACERTOU);
    errou_d      = (estado_d == FIM_ERROU);
  end

  // Control unit state and registered Moore outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q     <= INICIAL;
      zera_c_q     <= 1'b0;
      zera_r_q     <= 1'b0;
      registra_r_q <= 1'b0;
      conta_c_q    <= 1'b0;
      pronto_q     <= 1'b0;
      acertou_q    <= 1'b0;
      errou_q      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      zera_c_q     <= zera_c_d;
      zera_r_q     <= zera_r_d;
      registra_r_q <= registra_r_d;
      conta_c_q    <= conta_c_d;
      pronto_q     <= pronto_d;
      acertou_q    <= acertou_d;
      errou_q      <= errou_d;
    end
  end

  // Play counter: clear beats count, wraps naturally at 15.
  always_ff @(posedge clock) begin
    if (!reset)         contagem_q <= 4'd0;
    else if (zera_c_q)  contagem_q <= 4'd0;
    else if (conta_c_q) contagem_q <= contagem_q + 4'd1;
    else                contagem_q <= contagem_q;
  end

  // Switch register.
  always_ff @(posedge clock) begin
    if (!reset)            chaves_q <= 4'd0;
    else if (zera_r_q)     chaves_q <= 4'd0;
    else if (registra_r_q) chaves_q <= chaves;
    else                   chaves_q <= chaves_q;
  end

  // Unused state encodings show F on the display.
  always_comb begin
    estado_cod_s = 4'hF;
    case (estado_q)
      INICIAL, PREPARACAO, REGISTRA, COMPARACAO,
      PROXIMO, FIM_ACERTOU, FIM_ERROU: estado_cod_s = estado_q;
      default:                         estado_cod_s = 4'hF;
    endcase
  end

  assign memoria_s    = rom_word(contagem_q);
  assign igual_s      = (chaves_q == memoria_s);
  assign fim_c_s      = (contagem_q == 4'd15);

  assign pronto       = pronto_q;
  assign acertou      = acertou_q;
  assign errou        = errou_q;
  assign maior        = (chaves_q > memoria_s);
  assign menor        = (chaves_q < memoria_s);
  assign db_igual     = igual_s;
  assign db_iniciar   = iniciar;
  assign db_zeraC     = zera_c_q;
  assign db_zeraR     = zera_r_q;
  assign db_registraR = registra_r_q;
  assign db_contaC    = conta_c_q;
  assign db_fimC      = fim_c_s;
  assign db_contagem  = hex7seg(contagem_q);
  assign db_memoria   = hex7seg(memoria_s);
  assign db_chaves    = hex7seg(chaves_q);
  assign db_estado    = hex7seg(estado_cod_s);

endmodule

// File: tb/tb_circuito_exp_4.sv
// Scoreboard bench for circuito_exp_4: expected compare results are queued per play
// and checked when the design reaches its compare state.
module tb_circuito_exp_4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] chaves = 4'd0;
  logic       pronto, acertou, errou, maior, menor, db_igual, db_iniciar;
  logic       db_zeraC, db_zeraR, db_registraR, db_contaC, db_fimC;
  logic [6:0] db_contagem, db_memoria, db_chaves, db_estado;

  circuito_exp_4 dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .pronto(pronto), .acertou(acertou), .errou(errou), .maior(maior), .menor(menor),
    .db_igual(db_igual), .db_iniciar(db_iniciar), .db_zeraC(db_zeraC), .db_zeraR(db_zeraR),
    .db_registraR(db_registraR), .db_contaC(db_contaC), .db_fimC(db_fimC),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_chaves(db_chaves),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       igual;
    logic       maior;
    logic       menor;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] rom_m [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                             4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
  logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] cnt_m;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cnt_m = 4'd0;
  endtask

  // Pulse iniciar from inicial or an end state; leaves the design in registra.
  task automatic start_game();
    iniciar = 1'b1;
    #1;
    n_cmp++;
    if (db_iniciar !== 1'b1) begin
      n_bad++; $display("FAIL db_iniciar: got %b want 1", db_iniciar);
    end
    tick();
    iniciar = 1'b0;
    n_cmp++;
    if (db_estado !== seg[1] || db_zeraC !== 1'b1 || db_zeraR !== 1'b1) begin
      n_bad++; $display("FAIL preparacao: estado=%h zeraC=%b zeraR=%b", db_estado, db_zeraC, db_zeraR);
    end
    tick();
    cnt_m = 4'd0;
    n_cmp++;
    if (db_estado !== seg[4] || db_registraR !== 1'b1 || db_contagem !== seg[0] || db_chaves !== seg[0]) begin
      n_bad++; $display("FAIL registra_entry: estado=%h regR=%b cont=%h chv=%h", db_estado, db_registraR, db_contagem, db_chaves);
    end
  endtask

  // One play from registra: queue the expectation, check it in comparacao, advance.
  task automatic play(input logic [3:0] v);
    exp_t e, o;
    int   guard;
    e.igual = (v == rom_m[cnt_m]);
    e.maior = (v > rom_m[cnt_m]);
    e.menor = (v < rom_m[cnt_m]);
    e.cnt   = cnt_m;
    sb.push_back(e);
    chaves = v;
    tick();
    chaves = ~v;
    guard = 0;
    while (db_estado !== seg[5] && guard < 4) begin
      tick();
      guard++;
    end
    o = sb.pop_front();
    n_cmp++;
    if (db_estado !== seg[5]) begin
      n_bad++; $display("FAIL comparacao_timeout: estado=%h", db_estado);
    end else if (db_igual !== o.igual || maior !== o.maior || menor !== o.menor ||
                 db_contagem !== seg[o.cnt] || db_chaves !== seg[v]) begin
      n_bad++;
      $display("FAIL compare_play%0d: got ig/ma/me=%b%b%b cont=%h want %b%b%b cont=%h",
               o.cnt, db_igual, maior, menor, db_contagem, o.igual, o.maior, o.menor, seg[o.cnt]);
    end
    tick();
    if (o.igual && o.cnt != 4'd15) begin
      n_cmp++;
      if (db_estado !== seg[6] || db_contaC !== 1'b1) begin
        n_bad++; $display("FAIL proximo: estado=%h contaC=%b", db_estado, db_contaC);
      end
      tick();
      cnt_m = cnt_m + 4'd1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (db_estado !== seg[0] || pronto !== 1'b0 || acertou !== 1'b0 || errou !== 1'b0 ||
        db_contagem !== seg[0] || db_chaves !== seg[0] || db_memoria !== seg[1]) begin
      n_bad++;
      $display("FAIL reset: estado=%h p/a/e=%b%b%b cont=%h chv=%h mem=%h",
               db_estado, pronto, acertou, errou, db_contagem, db_chaves, db_memoria);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (db_estado !== seg[0] || db_zeraC || db_zeraR || db_registraR || db_contaC || pronto) begin
        n_bad++; $display("FAIL idle%0d: estado=%h", i, db_estado);
      end
    end
  endtask

  task automatic test_full_game();
    do_reset();
    start_game();
    for (int i = 0; i < 16; i++) play(rom_m[i]);
    n_cmp++;
    if (db_estado !== seg[10] || pronto !== 1'b1 || acertou !== 1'b1 || errou !== 1'b0 ||
        db_fimC !== 1'b1 || db_contagem !== seg[15]) begin
      n_bad++;
      $display("FAIL fim_acertou: estado=%h p/a/e=%b%b%b fimC=%b cont=%h want estado=%h",
               db_estado, pronto, acertou, errou, db_fimC, db_contagem, seg[10]);
    end
    tick();
    n_cmp++;
    if (db_estado !== seg[10]) begin
      n_bad++; $display("FAIL acertou_hold: estado=%h want %h", db_estado, seg[10]);
    end
  endtask

  task automatic test_error();
    logic [3:0] seq [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    do_reset();
    start_game();
    for (int i = 0; i < 5; i++) play(seq[i]);
    n_cmp++;
    if (db_estado !== seg[14] || pronto !== 1'b1 || errou !== 1'b1 || acertou !== 1'b0 ||
        db_contagem !== seg[4] || db_chaves !== seg[1]) begin
      n_bad++;
      $display("FAIL fim_errou: estado=%h p/a/e=%b%b%b cont=%h want estado=%h cont=%h",
               db_estado, pronto, acertou, errou, db_contagem, seg[14], seg[4]);
    end
  endtask

  task automatic test_restart();
    start_game();
    for (int i = 0; i < 3; i++) play(rom_m[i]);
    n_cmp++;
    if (db_estado !== seg[4] || db_contagem !== seg[3] || pronto !== 1'b0) begin
      n_bad++; $display("FAIL restart_progress: estado=%h cont=%h", db_estado, db_contagem);
    end
  endtask

  task automatic test_reset_midgame();
    do_reset();
    start_game();
    for (int i = 0; i < 3; i++) play(rom_m[i]);
    chaves = 4'h8;
    tick();
    n_cmp++;
    if (db_estado !== seg[5] || db_chaves !== seg[8]) begin
      n_bad++; $display("FAIL midgame_cmp: estado=%h chv=%h", db_estado, db_chaves);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++;
    if (db_estado !== seg[0] || db_contagem !== seg[0] || db_chaves !== seg[0] || db_contaC !== 1'b0) begin
      n_bad++;
      $display("FAIL midgame_reset: estado=%h cont=%h chv=%h", db_estado, db_contagem, db_chaves);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_idle();
    test_full_game();
    test_error();
    test_restart();
    test_reset_midgame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/circuito_exp_4.md
# circuito_exp_4

Sequence-checking game circuit: a control unit (Moore FSM) driving a datapath. The datapath holds a 4-bit play counter, a 16×4 sequence ROM, a 4-bit switch register and a magnitude comparator. After `iniciar`, the circuit samples `chaves` once per 3-cycle play and checks it against the stored sequence. It ends in an "acertou" (all 16 correct) or "errou" (first mismatch) state. Debug outputs drive the board's 7-segment displays and LEDs.

## Interface
- No parameters.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `iniciar` in 1: start request, level-sampled.
- `chaves` in 4: player's switch input.
- `pronto` out 1: game finished (either end state).
- `acertou` out 1: finished, all 16 plays correct.
- `errou` out 1: finished on a mismatch.
- `maior` out 1: registered chaves > ROM word (unsigned).
- `menor` out 1: registered chaves < ROM word (unsigned).
- `db_igual` out 1: registered chaves == ROM word.
- `db_iniciar` out 1: copy of `iniciar`.
- `db_zeraC`, `db_zeraR`, `db_registraR`, `db_contaC` out 1 each: FSM control signals.
- `db_fimC` out 1: counter == 15.
- `db_contagem` out 7: 7-segment hex display of the counter.
- `db_memoria` out 7: 7-segment display of the ROM word.
- `db_chaves` out 7: 7-segment display of the switch register.
- `db_estado` out 7: 7-segment display of the state code.

## Operation
- **ROM contents**, addresses 0..15: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (hex). Asynchronous read, addressed by the counter.
- **Counter**: 4-bit.
  - Synchronous clear on `zeraC` (priority over `contaC`).
  - Increments on `contaC`; wraps 15→0.
  - `fimC` = (count==15), combinational.
- **Register**: 4-bit.
  - Synchronous clear on `zeraR` (priority).
  - Loads `chaves` on `registraR`.
- **Comparator**: combinational on register vs ROM word; produces igual/maior/menor.
- **FSM states** (`db_estado` code):
  - inicial 0
  - preparacao 1
  - registra 4
  - comparacao 5
  - proximo 6
  - fim_acertou A
  - fim_errou E
  - Unused codes display F and return to inicial on the next edge.
- **Transitions**:
  - inicial: `iniciar`=1 → preparacao, else stay.
  - preparacao → registra.
  - registra → comparacao.
  - comparacao: !igual → fim_errou; igual & fimC → fim_acertou; igual & !fimC → proximo.
  - proximo → registra.
  - fim_*: `iniciar`=1 → preparacao, else stay.
- **Moore outputs**:
  - preparacao: zeraC=1, zeraR=1.
  - registra: registraR=1.
  - proximo: contaC=1.
  - fim_acertou: pronto=1, acertou=1.
  - fim_errou: pronto=1, errou=1.
  - All others 0.
- **Hex-to-7-segment**: active-low segments, bit order {g,f,e,d,c,b,a}.
  - Standard glyphs for 0–F.
  - `db_estado` uses the same decoder on the 4-bit state code.

## Timing
- **Reset** (`reset`=0 at a rising edge):
  - State → inicial; counter=0; register=0.
  - pronto=acertou=errou=0; all control outputs 0.
  - `db_contagem` shows 0; `db_chaves` shows 0; `db_memoria` shows 1.
- Reset has priority over every transition, including mid-game: the next state is inicial regardless of state.
- **Start**: edge k samples `iniciar`=1 (in inicial) → preparacao. At k+1 the counter and register clear and the state becomes registra.
- **One play = 3 cycles** (registra, comparacao, proximo).
  - `chaves` is captured at the edge leaving registra.
  - The compare uses that value during comparacao.
  - The counter increments at the edge leaving proximo.
- `chaves` held stable for any 3-cycle window is sampled exactly once per play.
- **Full correct game**: 16 plays. fim_acertou is entered at the edge leaving the 16th comparacao, with counter=15 (not incremented).
- **Mismatch at play n** (0-based): fim_errou is entered with counter=n.
- The counter and register keep their values in end states.
- `db_iniciar` and all comparator outputs are purely combinational; zero latency.

## Test plan
- **Reset**: reset=0 for 1 cycle → db_estado shows 0; pronto/acertou/errou=0; db_contagem shows 0.
- **Idle**: `iniciar`=0 for 5 cycles after reset → state stays inicial; no control strobes.
- **Full correct game**: `iniciar` pulse, then `chaves` = 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4, each held 3 cycles in phase with registra.
  - Expect db_igual=1 in every comparacao.
  - Expect fim_acertou: pronto=1, acertou=1, errou=0, db_fimC=1, db_estado shows A.
- **Error at play 4**: reset, start, then `chaves` = 1,2,4,8,1.
  - At the 5th comparacao, register=1 vs ROM=4: menor=1, maior=0.
  - Expect fim_errou: pronto=1, errou=1, db_contagem shows 4, db_estado shows E.
- **Restart**: from fim_errou, pulse `iniciar` → preparacao; counter and register cleared; a new game proceeds normally.
- **Reset mid-game**: assert reset during comparacao of play 3 → next edge gives state inicial, counter=0, register=0.
